mac_seq: RTL and testbench

Sequencer that drives the signed 8x8 MAC datapath (26-bit accumulator, synchronous clear) to compute one dot product of two vectors held in synchronous-read memories.
- On a start pulse it generates memory addresses, gates read data into the MAC operand inputs, and manages the accumulator clear.
- When the accumulation is final it captures the accumulator, scales and saturates it to a signed 8-bit result, and pulses done.
- It sits between the layer-level control FSM and the MAC/weight/input memories.

---
 rtl/mac_seq_if.sv | 29 ++
 rtl/mac_seq.sv | 143 ++++++++++++++
 tb/tb_mac_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_if.sv
// mac_seq_if: bus between the dot-product sequencer and its datapath.
// Carries the read side of the two operand memories (shared read enable,
// one address and one data bus per memory) and the MAC operand / clear /
// accumulator signals.
//   master : sequencer side (drives mem_re, addresses, MAC operands, clear)
//   slave  : memory + MAC side (drives read data and accumulator)
interface mac_seq_if #(
    parameter int ADDR_W = 10
);
    logic              mem_re;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        rd_a_data;
    logic [7:0]        rd_b_data;
    logic [7:0]        mac_a;
    logic [7:0]        mac_b;
    logic              mac_clr;
    logic [25:0]       mac_acc;

    modport master (
        output mem_re, addr_a, addr_b, mac_a, mac_b, mac_clr,
        input  rd_a_data, rd_b_data, mac_acc
    );

    modport slave (
        input  mem_re, addr_a, addr_b, mac_a, mac_b, mac_clr,
        output rd_a_data, rd_b_data, mac_acc
    );
endinterface

// File: rtl/mac_seq.sv
// mac_seq: sequencer for one signed dot product on an 8x8 MAC with a 26-bit
// accumulator. On start it reads len element pairs from two synchronous-read
// memories, gates the returned data into the MAC, then scales the final
// accumulator by SHIFT, saturates it to signed 8 bits and pulses done.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, len          job request (sampled only in IDLE) and element count
//   base_a, base_b      first addresses of vectors A and B (sampled with start)
//   bus (master)        memory read bus and MAC operand/clear/accumulator
//   result              signed saturated result, held until the next job ends
//   busy                high in every state except IDLE
//   done                one-cycle pulse, result valid in the same cycle
module mac_seq #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int SHIFT  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    mac_seq_if.master         bus,
    output logic [7:0]        result,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic              rd_vld_q, rd_vld_d;
    logic              done_q, done_d;
    logic [7:0]        result_q, result_d;

    logic              run;
    logic signed [25:0] acc_shifted;
    logic [7:0]        sat_val;

    // Scale and saturate the accumulator to signed 8 bits.
    always_comb begin
        acc_shifted = $signed(bus.mac_acc) >>> SHIFT;
        if (acc_shifted > 26'sd127) begin
            sat_val = 8'h7F;
        end else if (acc_shifted < -26'sd128) begin
            sat_val = 8'h80;
        end else begin
            sat_val = acc_shifted[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    idx_d    = '0;
                    // A zero-length job skips straight to capture; the
                    // accumulator is still cleared so the result is 0.
                    state_d  = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                idx_d = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last read data reaches the MAC during this cycle.
                state_d = S_DONE;
            end
            S_DONE: begin
                // Accumulator now holds every product.
                result_d = sat_val;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign run      = (state_q == S_RUN);
    assign rd_vld_d = run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            rd_vld_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            rd_vld_q <= rd_vld_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Addresses wrap naturally through the ADDR_W-bit adders.
    assign bus.mem_re  = run;
    assign bus.addr_a  = run ? (base_a_q + ADDR_W'(idx_q)) : '0;
    assign bus.addr_b  = run ? (base_b_q + ADDR_W'(idx_q)) : '0;

    // The MAC adds every cycle, so invalid cycles must contribute zero.
    assign bus.mac_a   = rd_vld_q ? bus.rd_a_data : 8'h00;
    assign bus.mac_b   = rd_vld_q ? bus.rd_b_data : 8'h00;
    assign bus.mac_clr = (state_q == S_IDLE);

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] len;
    logic [9:0] base_a;
    logic [9:0] base_b;
    logic [7:0] result;
    logic       busy;
    logic       done;

    mac_seq_if #(.ADDR_W(10)) bus ();

    mac_seq #(.ADDR_W(10), .LEN_W(10), .SHIFT(7)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len),
        .base_a (base_a),
        .base_b (base_b),
        .bus    (bus),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: two synchronous-read memories and a signed 8x8 MAC.
    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];
    logic signed [15:0] prod;

    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.rd_a_data <= mem_a[bus.addr_a];
            bus.rd_b_data <= mem_b[bus.addr_b];
        end
    end

    assign prod = $signed(bus.mac_a) * $signed(bus.mac_b);

    always @(posedge clk) begin
        if (bus.mac_clr) bus.mac_acc <= '0;
        else             bus.mac_acc <= bus.mac_acc + {{10{prod[15]}}, prod};
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input int l, input int ba, input int bb);
        int acc;
        int a;
        int b;
        acc = 0;
        for (int i = 0; i < l; i++) begin
            a = $signed(mem_a[(ba + i) % 1024]);
            b = $signed(mem_b[(bb + i) % 1024]);
            acc += a * b;
        end
        acc = acc >>> 7;
        if (acc > 127)       return 8'h7F;
        else if (acc < -128) return 8'h80;
        else                 return acc[7:0];
    endfunction

    task automatic issue(input int l, input int ba, input int bb);
        start  = 1'b1;
        len    = 10'(l);
        base_a = 10'(ba);
        base_b = 10'(bb);
        exp_q.push_back(model(l, ba, bb));
        $display("[TB] issue len=%0d base_a=%03h base_b=%03h expect=%02h", l, ba, bb, model(l, ba, bb));
    endtask

    // Runs one job, checking every cycle from the start edge to the done cycle.
    task automatic run_job(input int l, input int ba, input int bb, input bit pre,
                           input bit poke, input bit chain,
                           input int nl, input int nba, input int nbb);
        int d;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] er;
        bit   ere;
        if (!pre) begin
            @(negedge clk);
            issue(l, ba, bb);
        end
        d = (l == 0) ? 2 : l + 3;
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke && k == 2) begin
                start = 1'b1; len = 10'd1; base_a = 10'h200; base_b = 10'h200;
            end
            if (poke && k == 3) start = 1'b0;
            ere = (k <= l);
            check("mem_re", 32'(bus.mem_re), 32'(ere));
            if (ere) begin
                check("addr_a", 32'(bus.addr_a), 32'((ba + k - 1) % 1024));
                check("addr_b", 32'(bus.addr_b), 32'((bb + k - 1) % 1024));
            end
            ea = (k >= 2 && k <= l + 1) ? mem_a[(ba + k - 2) % 1024] : 8'h00;
            eb = (k >= 2 && k <= l + 1) ? mem_b[(bb + k - 2) % 1024] : 8'h00;
            check("mac_a", 32'(bus.mac_a), 32'(ea));
            check("mac_b", 32'(bus.mac_b), 32'(eb));
            check("busy", 32'(busy), 32'(k < d));
            check("mac_clr", 32'(bus.mac_clr), 32'(k >= d));
            check("done", 32'(done), 32'(k == d));
            if (k == d) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'(1), 32'(0));
                end else begin
                    er = exp_q.pop_front();
                    check("result", 32'(result), 32'(er));
                    $display("[TB] done len=%0d result=%02h expected=%02h", l, result, er);
                end
                if (chain) issue(nl, nba, nbb);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        len    = '0;
        base_a = '0;
        base_b = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mem_re", 32'(bus.mem_re), 32'h0);
        check("rst_addr_a", 32'(bus.addr_a), 32'h0);
        check("rst_addr_b", 32'(bus.addr_b), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mac_a", 32'(bus.mac_a), 32'h0);
        rst_n = 1'b1;

        // Basic: 4 x 0x20*0x20 = 4096 -> 0x20
        for (int i = 0; i < 4; i++) begin mem_a[i] = 8'h20; mem_b[i] = 8'h20; end
        run_job(4, 0, 0, 0, 0, 0, 0, 0, 0);

        // Negative saturation
        for (int i = 0; i < 4; i++) begin mem_a[i] = 8'h80; mem_b[i] = 8'h7F; end
        run_job(4, 0, 0, 0, 0, 0, 0, 0, 0);

        // Positive saturation at exactly 128
        for (int i = 0; i < 4; i++) begin mem_a[i] = 8'h40; mem_b[i] = 8'h40; end
        run_job(4, 0, 0, 0, 0, 0, 0, 0, 0);

        // Zero length
        run_job(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Address wrap with mixed signs, sum 0
        mem_a[10'h3FE] = 8'h01; mem_a[10'h3FF] = 8'hFF; mem_a[10'h000] = 8'h02; mem_a[10'h001] = 8'hFE;
        mem_b[10'h001] = 8'h7F; mem_b[10'h002] = 8'h7F; mem_b[10'h003] = 8'h40; mem_b[10'h004] = 8'h40;
        run_job(4, 10'h3FE, 10'h001, 0, 0, 0, 0, 0, 0);

        // Start while busy ignored, then start coincident with done
        for (int i = 0; i < 5; i++) begin
            mem_a[10'h100 + i] = 8'(i * 16 + 3);
            mem_b[10'h100 + i] = 8'(-(i * 7) - 5);
        end
        for (int i = 0; i < 3; i++) begin mem_a[10'h180 + i] = 8'h20; mem_b[10'h180 + i] = 8'h20; end
        mem_a[10'h200] = 8'h7F; mem_b[10'h200] = 8'h7F;
        run_job(5, 10'h100, 10'h100, 0, 1, 1, 3, 10'h180, 10'h180);
        run_job(3, 10'h180, 10'h180, 1, 0, 0, 0, 0, 0);

        // Reset mid-RUN aborts the job
        for (int i = 0; i < 8; i++) begin
            mem_a[10'h300 + i] = 8'($urandom_range(0, 255));
            mem_b[10'h300 + i] = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        issue(8, 10'h300, 10'h300);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_mem_re", 32'(bus.mem_re), 32'h0);
        check("abort_result", 32'(result), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_mac_clr", 32'(bus.mac_clr), 32'h1);
        check("abort_mac_a", 32'(bus.mac_a), 32'h0);
        $display("[TB] reset asserted mid-run, job aborted");
        void'(exp_q.pop_back());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_idle", 32'(busy), 32'h0);
        end

        // Fresh job after abort
        run_job(8, 10'h300, 10'h300, 0, 0, 0, 0, 0, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
